// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter: the bus-owner state encoding
// and the select codes that steer the memory-port mux.
package mem_arb_pkg;

    // Owner of the memory port in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_DMA  = 2'b10
    } st_t;

    // Memory-port mux select codes (same values as the owner states).
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CPU  = 2'b01;
    localparam logic [1:0] SEL_DMA  = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk    : clock, updates on posedge
//   rst_n  : synchronous active-low reset, forces count to 0
//   inc    : count one event (holds at MAX once reached)
//   clr    : clear to 0; with inc also high the count restarts at 1
//   count  : current value, 0..MAX
//   at_max : count == MAX
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == WIDTH'(MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr && inc) begin
            // Restart: this event is the first of a new run.
            count <= WIDTH'(1);
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the single synchronous-read memory port between the CPU and a
// DMA/video fetch engine. The CPU normally wins; a starvation counter forces
// a DMA slot after MAX_WAIT denied cycles, and dma_lock lets the DMA keep the
// port for up to BURST_MAX consecutive grants.
//   CLK, R                         : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata          : CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid            : CPU access this cycle / read data on rdata
//   dma_req/lock/we/addr/wdata     : DMA request (held until dma_gnt)
//   dma_gnt, dma_rvalid            : DMA access this cycle / read data on rdata
//   rdata                          : shared read data (mem_dout passthrough)
//   mem_we, mem_addr, mem_din      : memory port controls
//   mem_dout                       : memory read data, one cycle after address
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    st_t           st;
    st_t           st_next;
    logic [1:0]    sel;
    logic [WW-1:0] wait_cnt;
    logic          wait_at_max;
    logic [BW-1:0] burst_cnt;
    logic          burst_at_max;

    // Grant decision, first match wins. Nothing is granted while in reset.
    always_comb begin
        sel = SEL_NONE;
        if (!R) begin
            sel = SEL_NONE;
        end else if (st == ST_DMA && dma_lock && dma_req && !burst_at_max) begin
            sel = SEL_DMA;
        end else if (dma_req && wait_at_max) begin
            sel = SEL_DMA;
        end else if (cpu_req) begin
            sel = SEL_CPU;
        end else if (dma_req) begin
            sel = SEL_DMA;
        end
    end

    assign cpu_gnt = (sel == SEL_CPU);
    assign dma_gnt = (sel == SEL_DMA);

    // Memory-port mux; an unowned port is driven to all zeros.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (sel)
            SEL_CPU: begin
                mem_we   = cpu_we;
                mem_addr = cpu_addr;
                mem_din  = cpu_wdata;
            end
            SEL_DMA: begin
                mem_we   = dma_we;
                mem_addr = dma_addr;
                mem_din  = dma_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        st_next = ST_IDLE;
        case (sel)
            SEL_CPU: st_next = ST_CPU;
            SEL_DMA: st_next = ST_DMA;
            default: st_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            st         <= ST_IDLE;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            st         <= st_next;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
        end
    end

    // Consecutive cycles the DMA asked and was refused.
    sat_counter #(.WIDTH(WW), .MAX(MAX_WAIT)) u_wait (
        .clk    (CLK),
        .rst_n  (R),
        .inc    (dma_req && !dma_gnt),
        .clr    (dma_gnt || !dma_req),
        .count  (wait_cnt),
        .at_max (wait_at_max)
    );

    // Length of the current run of DMA grants; a grant that does not follow
    // a DMA cycle restarts the run at 1, any non-DMA cycle clears it.
    sat_counter #(.WIDTH(BW), .MAX(BURST_MAX)) u_burst (
        .clk    (CLK),
        .rst_n  (R),
        .inc    (dma_gnt),
        .clr    (st != ST_DMA || !dma_gnt),
        .count  (burst_cnt),
        .at_max (burst_at_max)
    );

    assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic against a behavioural model of the arbitration rules
// and an independent shadow of memory contents.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic        CLK = 1'b0;
    logic        R;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic        dma_req, dma_lock, dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [7:0]  rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    int compared   = 0;
    int mismatched = 0;

    mem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .CLK        (CLK),
        .R          (R),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_lock   (dma_lock),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .rdata      (rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 CLK = ~CLK;

    // Background contents of never-written locations (0x1234 holds 0xA5).
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    // Synchronous-read memory attached to the arbiter.
    logic [7:0] env_mem [0:65535] = '{default: 8'h00};
    logic       env_wr  [0:65535] = '{default: 1'b0};

    always @(posedge CLK) begin
        mem_dout <= env_wr[mem_addr] ? env_mem[mem_addr] : pat(mem_addr);
        if (mem_we) begin
            env_mem[mem_addr] <= mem_din;
            env_wr[mem_addr]  <= 1'b1;
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [int];
    int         m_prev  = 0;     // 0 none, 1 cpu, 2 dma
    int         m_wait  = 0;
    int         m_burst = 0;
    bit         m_cpu_rv = 1'b0;
    bit         m_dma_rv = 1'b0;
    logic [7:0] m_rdata  = 8'h00;
    int         e_owner  = 0;
    logic       e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_din;

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pat(a);
    endfunction

    task automatic model_eval();
        if (!R)                                                                  e_owner = 0;
        else if (m_prev == 2 && dma_lock && dma_req && m_burst < BURST_MAX)      e_owner = 2;
        else if (dma_req && m_wait >= MAX_WAIT)                                  e_owner = 2;
        else if (cpu_req)                                                        e_owner = 1;
        else if (dma_req)                                                        e_owner = 2;
        else                                                                     e_owner = 0;
        e_we   = (e_owner == 1) ? cpu_we    : (e_owner == 2) ? dma_we    : 1'b0;
        e_addr = (e_owner == 1) ? cpu_addr  : (e_owner == 2) ? dma_addr  : 16'h0000;
        e_din  = (e_owner == 1) ? cpu_wdata : (e_owner == 2) ? dma_wdata : 8'h00;
    endtask

    task automatic model_commit();
        if (!R) begin
            m_prev = 0; m_wait = 0; m_burst = 0; m_cpu_rv = 0; m_dma_rv = 0;
        end else begin
            m_cpu_rv = (e_owner == 1) && !cpu_we;
            m_dma_rv = (e_owner == 2) && !dma_we;
            if (e_owner != 0) begin
                if (e_we) ref_mem[int'(e_addr)] = e_din;
                else      m_rdata = ref_read(e_addr);
            end
            if (e_owner == 2 || !dma_req) m_wait = 0;
            else if (m_wait < MAX_WAIT)   m_wait = m_wait + 1;
            if (e_owner != 2)             m_burst = 0;
            else if (m_prev != 2)         m_burst = 1;
            else if (m_burst < BURST_MAX) m_burst = m_burst + 1;
            m_prev = e_owner;
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        model_eval();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_commit();
        #1;
    endtask

    task automatic go_idle();
        cpu_req = 0; dma_req = 0; dma_lock = 0;
        repeat (2) begin settle(); advance(); end
    endtask

    task automatic test_reset();
        R = 0; cpu_req = 1; dma_req = 1; dma_lock = 0;
        cpu_we = 0; dma_we = 0; cpu_addr = 16'h1111; dma_addr = 16'h2222;
        cpu_wdata = 8'h11; dma_wdata = 8'h22;
        for (int i = 0; i < 2; i++) begin
            settle();
            compared++; if (cpu_gnt !== 1'b0) begin mismatched++; $display("FAIL reset_cpu_gnt cyc=%0d got=%b exp=0", i, cpu_gnt); end
            compared++; if (dma_gnt !== 1'b0) begin mismatched++; $display("FAIL reset_dma_gnt cyc=%0d got=%b exp=0", i, dma_gnt); end
            compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_mem_we cyc=%0d got=%b exp=0", i, mem_we); end
            compared++; if (mem_addr !== 16'h0000) begin mismatched++; $display("FAIL reset_mem_addr cyc=%0d got=%h exp=0000", i, mem_addr); end
            compared++; if (mem_din !== 8'h00) begin mismatched++; $display("FAIL reset_mem_din cyc=%0d got=%h exp=00", i, mem_din); end
            advance();
            compared++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin mismatched++; $display("FAIL reset_rvalid cyc=%0d got=%b%b exp=00", i, cpu_rvalid, dma_rvalid); end
        end
        R = 1;
        settle();
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL post_reset_cpu_gnt got=%b exp=1", cpu_gnt); end
        compared++; if (dma_gnt !== 1'b0) begin mismatched++; $display("FAIL post_reset_dma_gnt got=%b exp=0", dma_gnt); end
        compared++; if (dut.wait_cnt !== 0) begin mismatched++; $display("FAIL post_reset_wait_cnt got=%0d exp=0", dut.wait_cnt); end
        advance();
        go_idle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        settle();
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL rd_cpu_gnt got=%b exp=1", cpu_gnt); end
        compared++; if (mem_addr !== 16'h1234) begin mismatched++; $display("FAIL rd_mem_addr got=%h exp=1234", mem_addr); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
        advance();
        cpu_req = 0;
        settle();
        compared++; if (cpu_rvalid !== 1'b1) begin mismatched++; $display("FAIL rd_cpu_rvalid got=%b exp=1", cpu_rvalid); end
        compared++; if (rdata !== 8'hA5) begin mismatched++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
        compared++; if (dma_rvalid !== 1'b0) begin mismatched++; $display("FAIL rd_dma_rvalid got=%b exp=0", dma_rvalid); end
        advance();
        go_idle();
    endtask

    task automatic test_starvation();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0020; dma_lock = 0;
        for (int i = 0; i < 15; i++) begin
            bit exp_dma;
            exp_dma = (i % 5 == 4);
            settle();
            compared++; if (dma_gnt !== exp_dma) begin mismatched++; $display("FAIL starve_dma_gnt cyc=%0d got=%b exp=%b", i, dma_gnt, exp_dma); end
            compared++; if (cpu_gnt !== !exp_dma) begin mismatched++; $display("FAIL starve_cpu_gnt cyc=%0d got=%b exp=%b", i, cpu_gnt, !exp_dma); end
            if (exp_dma) begin
                compared++; if (dut.wait_cnt !== 3'(MAX_WAIT)) begin mismatched++; $display("FAIL starve_wait_cnt cyc=%0d got=%0d exp=%0d", i, dut.wait_cnt, MAX_WAIT); end
            end
            advance();
        end
        go_idle();
    endtask

    task automatic test_burst();
        cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0030;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0040; dma_lock = 1;
        for (int i = 0; i <= BURST_MAX; i++) begin
            bit exp_dma;
            if (i == 1) cpu_req = 1;
            exp_dma = (i < BURST_MAX);
            settle();
            compared++; if (dma_gnt !== exp_dma) begin mismatched++; $display("FAIL burst_dma_gnt cyc=%0d got=%b exp=%b", i, dma_gnt, exp_dma); end
            compared++; if (cpu_gnt !== !exp_dma) begin mismatched++; $display("FAIL burst_cpu_gnt cyc=%0d got=%b exp=%b", i, cpu_gnt, !exp_dma); end
            advance();
        end
        go_idle();
    endtask

    task automatic test_write_path();
        dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 8'h3C; dma_lock = 0;
        cpu_req = 0;
        settle();
        compared++; if (dma_gnt !== 1'b1) begin mismatched++; $display("FAIL wr_dma_gnt got=%b exp=1", dma_gnt); end
        compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
        compared++; if (mem_addr !== 16'h0200) begin mismatched++; $display("FAIL wr_mem_addr got=%h exp=0200", mem_addr); end
        compared++; if (mem_din !== 8'h3C) begin mismatched++; $display("FAIL wr_mem_din got=%h exp=3c", mem_din); end
        advance();
        dma_req = 0; dma_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
        settle();
        compared++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin mismatched++; $display("FAIL wr_no_rvalid got=%b%b exp=00", cpu_rvalid, dma_rvalid); end
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL wr_rb_cpu_gnt got=%b exp=1", cpu_gnt); end
        advance();
        cpu_req = 0;
        settle();
        compared++; if (cpu_rvalid !== 1'b1) begin mismatched++; $display("FAIL wr_rb_rvalid got=%b exp=1", cpu_rvalid); end
        compared++; if (rdata !== 8'h3C) begin mismatched++; $display("FAIL wr_rb_rdata got=%h exp=3c", rdata); end
        advance();
        go_idle();
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 0;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0300; dma_lock = 1;
        settle();
        compared++; if (dma_gnt !== 1'b1) begin mismatched++; $display("FAIL rmid_dma_gnt got=%b exp=1", dma_gnt); end
        R = 0;
        advance();
        dma_req = 0; dma_lock = 0;
        settle();
        compared++; if (dma_rvalid !== 1'b0) begin mismatched++; $display("FAIL rmid_dma_rvalid got=%b exp=0", dma_rvalid); end
        compared++; if (dut.st !== ST_IDLE) begin mismatched++; $display("FAIL rmid_st got=%0d exp=%0d", dut.st, ST_IDLE); end
        compared++; if (dut.burst_cnt !== 0) begin mismatched++; $display("FAIL rmid_burst_cnt got=%0d exp=0", dut.burst_cnt); end
        advance();
        R = 1;
        go_idle();
    endtask

    task automatic test_random();
        bit cpu_hold = 0;
        bit dma_hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!cpu_hold) begin
                cpu_req   = ($urandom % 3) != 0;
                cpu_we    = $urandom % 2;
                cpu_addr  = 16'h0400 + 16'($urandom % 16);
                cpu_wdata = 8'($urandom);
            end
            if (!dma_hold) begin
                dma_req   = ($urandom % 3) != 0;
                dma_we    = $urandom % 2;
                dma_addr  = 16'h0400 + 16'($urandom % 16);
                dma_wdata = 8'($urandom);
            end
            dma_lock = ($urandom % 4) != 0;
            R = ($urandom % 40) != 0;
            settle();
            compared++; if (cpu_gnt !== (e_owner == 1)) begin mismatched++; $display("FAIL rnd_cpu_gnt cyc=%0d got=%b exp=%b", i, cpu_gnt, e_owner == 1); end
            compared++; if (dma_gnt !== (e_owner == 2)) begin mismatched++; $display("FAIL rnd_dma_gnt cyc=%0d got=%b exp=%b", i, dma_gnt, e_owner == 2); end
            compared++; if (mem_we !== e_we) begin mismatched++; $display("FAIL rnd_mem_we cyc=%0d got=%b exp=%b", i, mem_we, e_we); end
            compared++; if (mem_addr !== e_addr) begin mismatched++; $display("FAIL rnd_mem_addr cyc=%0d got=%h exp=%h", i, mem_addr, e_addr); end
            compared++; if (mem_din !== e_din) begin mismatched++; $display("FAIL rnd_mem_din cyc=%0d got=%h exp=%h", i, mem_din, e_din); end
            compared++; if (cpu_rvalid !== m_cpu_rv) begin mismatched++; $display("FAIL rnd_cpu_rvalid cyc=%0d got=%b exp=%b", i, cpu_rvalid, m_cpu_rv); end
            compared++; if (dma_rvalid !== m_dma_rv) begin mismatched++; $display("FAIL rnd_dma_rvalid cyc=%0d got=%b exp=%b", i, dma_rvalid, m_dma_rv); end
            compared++; if ((cpu_rvalid && dma_rvalid) !== 1'b0) begin mismatched++; $display("FAIL rnd_rvalid_onehot cyc=%0d got=%b%b exp=not both", i, cpu_rvalid, dma_rvalid); end
            if (m_cpu_rv || m_dma_rv) begin
                compared++; if (rdata !== m_rdata) begin mismatched++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", i, rdata, m_rdata); end
            end
            cpu_hold = cpu_req && (e_owner != 1);
            dma_hold = dma_req && (e_owner != 2);
            advance();
        end
        R = 1;
        go_idle();
    endtask

    initial begin
        R = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        test_reset();
        test_cpu_read();
        test_starvation();
        test_burst();
        test_write_path();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single shared MEMORY port (16-bit address, 8-bit data, synchronous read). Requesters are the CPU (port cpu_*) and a DMA/video fetch engine (port dma_*). The CPU has priority, but a starvation counter guarantees the DMA a slot, and an optional DMA lock permits bounded bursts. The block sits between both masters and MEMORY and drives its WE, Address and DataIn.

Parameters:
AW, 16, address width
DW, 8, data width
MAX_WAIT, 4, consecutive denied DMA cycles before the DMA is forced a grant (must be ≥1)
BURST_MAX, 8, maximum consecutive DMA grants held by dma_lock (must be ≥1)

Ports:
CLK  in  1  clock, all state updates on posedge
R  in  1  reset, synchronous, active-low (R==0 at posedge resets)
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU access committed this cycle
cpu_rvalid  out  1  CPU read data valid on rdata
dma_req  in  1  DMA access request
dma_lock  in  1  DMA asks to keep the bus for a burst
dma_we  in  1  1=write, 0=read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access committed this cycle
dma_rvalid  out  1  DMA read data valid on rdata
rdata  out  DW  shared read data, equal to mem_dout
mem_we  out  1  to MEMORY WE
mem_addr  out  AW  to MEMORY Address
mem_din  out  DW  to MEMORY DataIn
mem_dout  in  DW  from MEMORY DataOut, valid the cycle after the address

Behaviour:
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt. gnt is combinational in the same cycle, and the access occurs in that cycle. The requester may change inputs in the following cycle.
- Registered state: st (ST_IDLE/ST_CPU/ST_DMA, owner of the previous cycle), wait_cnt (0..MAX_WAIT), burst_cnt (0..BURST_MAX), cpu_rvalid, dma_rvalid.
- Reset (R==0 at posedge): st=ST_IDLE, wait_cnt=0, burst_cnt=0, both rvalid=0. While R==0: cpu_gnt=dma_gnt=0, mem_we=0, mem_addr=0, mem_din=0. Pending rvalid is dropped on reset mid-access.
- Grant priority, evaluated combinationally, first match wins:
  1. st==ST_DMA && dma_lock && dma_req && burst_cnt<BURST_MAX -> DMA
  2. dma_req && wait_cnt==MAX_WAIT -> DMA
  3. cpu_req -> CPU
  4. dma_req -> DMA
  5. otherwise none
- Next st = ST_CPU / ST_DMA / ST_IDLE according to the grant.
- wait_cnt: cleared if dma_gnt or !dma_req. Otherwise increments, saturating at MAX_WAIT.
- burst_cnt:
  - DMA grant with st==ST_DMA: +1, saturating at BURST_MAX.
  - DMA grant with st!=ST_DMA: 1.
  - No DMA grant: 0.
  - Once saturated, the lock is ineffective until a non-DMA cycle. The DMA still wins via rules 2 and 4.
- Memory mux: the owner's addr/we/wdata drive mem_*. With no owner: mem_we=0, mem_addr=0, mem_din=0.
- Read return: cpu_rvalid <= cpu_gnt && !cpu_we; dma_rvalid <= dma_gnt && !dma_we. Latency is exactly 1 cycle. rdata = mem_dout, unregistered. At most one rvalid is high in any cycle.
- Writes produce no rvalid.
- Back-to-back grants to alternating owners are legal every cycle. There are no idle turnaround cycles.

Decomposition:
- Package mem_arb_pkg holds:
  - st encodings ST_IDLE=2'b00, ST_CPU=2'b01, ST_DMA=2'b10
  - owner-select constants for the memory mux
- One sub-module, sat_counter (WIDTH, MAX; inputs inc, clr; output count, at_max), instantiated for wait_cnt and burst_cnt.
- The grant logic and mux stay in mem_arbiter.

Test Plan:
- Reset: hold R=0 for 2 cycles with both req=1 -> both gnt=0, mem_we=0, mem_addr=0. After R=1, the first cycle grants the CPU (wait_cnt=0).
- CPU read only: cpu_req=1, cpu_we=0, cpu_addr=16'h1234, memory holds 8'hA5 at 16'h1234 -> cpu_gnt same cycle, mem_addr=16'h1234, next cycle cpu_rvalid=1 and rdata=8'hA5, dma_rvalid=0.
- Starvation: cpu_req and dma_req held at 1 continuously, MAX_WAIT=4 -> grant pattern CPU,CPU,CPU,CPU,DMA repeating with period 5; wait_cnt reads 4 in each DMA cycle.
- Burst: CPU idle, DMA granted with dma_lock=1; cpu_req rises on the DMA's second grant cycle; BURST_MAX=8 -> exactly 8 consecutive DMA grants, then cpu_gnt.
- Write path: dma_req=1, dma_we=1, dma_addr=16'h0200, dma_wdata=8'h3C, CPU idle -> mem_we=1, mem_addr=16'h0200, mem_din=8'h3C, no rvalid next cycle. A subsequent CPU read of 16'h0200 returns 8'h3C.
- Reset mid-read: DMA read granted, R=0 on the next posedge -> dma_rvalid stays 0, st=ST_IDLE, burst_cnt=0.
